// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline sequencing controller: FSM encoding,
// action-priority codes and the default data-memory latency.
package arm_pipe_pkg;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Selected pipeline action, listed from highest to lowest priority
  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_MEM   = 2'd1;
  localparam logic [1:0] SEL_FLUSH = 2'd2;
  localparam logic [1:0] SEL_STALL = 2'd3;

  localparam int DEF_MEM_LAT = 4;

  function automatic logic [1:0] prio_select(input logic mem_freeze,
                                             input logic branch,
                                             input logic stall);
    logic [1:0] sel;
    sel = SEL_NONE;
    if (mem_freeze)  sel = SEL_MEM;
    else if (branch) sel = SEL_FLUSH;
    else if (stall)  sel = SEL_STALL;
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Event inputs, freeze/flush strobes and performance counters of the
// pipeline sequencing controller; master drives events, slave is the controller.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             exe_mem_read;
  logic             branch_taken;
  logic             mem_req;
  logic             perf_clr;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             freeze_back;
  logic             mem_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] wait_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output hazard_detected, exe_mem_read, branch_taken, mem_req, perf_clr,
    input  freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back,
    input  mem_busy, stall_cycles, wait_cycles, flush_events
  );

  modport slave (
    input  hazard_detected, exe_mem_read, branch_taken, mem_req, perf_clr,
    output freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back,
    output mem_busy, stall_cycles, wait_cycles, flush_events
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear;
// clear wins over increment and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (clr)                  r_cnt <= '0;
    else if (inc && (r_cnt != '1)) r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller: memory wait-state FSM, prioritised
// freeze/flush strobes and stall/wait/flush counters. Optional macro FORWARDING_EN.
module pipeline_stall_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);
  localparam int                WCNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit                MEM_EN    = (MEM_LAT > 0);
  localparam int                LOAD_I    = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = LOAD_I[WCNT_W-1:0];

  logic [0:0]        r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic              w_mem_freeze;
  logic              w_stall_req;
  logic [1:0]        w_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.mem_req && MEM_EN) begin
            r_state <= ST_MEM_WAIT;
            r_wcnt  <= WCNT_LOAD;
          end
        end
        default: begin
          if (r_wcnt != '0) r_wcnt  <= r_wcnt - WCNT_W'(1);
          else              r_state <= ST_RUN;
        end
      endcase
    end
  end

  // The access's first frozen cycle is the RUN cycle that sees mem_req
  assign w_mem_freeze = rst_n &&
                        (((r_state == ST_RUN) && bus.mem_req && MEM_EN) ||
                         ((r_state == ST_MEM_WAIT) && (r_wcnt != '0)));

`ifdef FORWARDING_EN
  assign w_stall_req = bus.hazard_detected & bus.exe_mem_read;
`else
  logic w_unused_ld;
  assign w_unused_ld = bus.exe_mem_read;
  assign w_stall_req = bus.hazard_detected;
`endif

  assign w_sel = rst_n ? prio_select(w_mem_freeze, bus.branch_taken, w_stall_req)
                       : SEL_NONE;

  assign bus.freeze_pc    = (w_sel == SEL_MEM) || (w_sel == SEL_STALL);
  assign bus.freeze_if_id = (w_sel == SEL_MEM) || (w_sel == SEL_STALL);
  assign bus.flush_if_id  = (w_sel == SEL_FLUSH);
  assign bus.flush_id_exe = (w_sel == SEL_FLUSH) || (w_sel == SEL_STALL);
  assign bus.freeze_back  = (w_sel == SEL_MEM);
  assign bus.mem_busy     = rst_n && (r_state == ST_MEM_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.perf_clr),
    .inc   (w_sel == SEL_STALL),
    .cnt   (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.perf_clr),
    .inc   (w_mem_freeze),
    .cnt   (bus.wait_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.perf_clr),
    .inc   (w_sel == SEL_FLUSH),
    .cnt   (bus.flush_events)
  );
endmodule
